noc_traffic_gen: RTL and testbench

Parametrised per-node traffic generator and receive checker for the NoC fabric bench, and the next generation of the single-shot test node. Each instance injects a programmed burst of multi-flit packets with configurable length, inter-packet gap and destination pattern (fixed, pseudo-random, transpose, neighbour). It also checks every packet ejected at its own node. One instance sits on the local port of each router, and its counters feed bench-level scoreboarding.

---
 rtl/noc_traffic_gen.sv | 274 +++++++++++++++++++++++++++
 tb/tb_noc_traffic_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_traffic_gen.sv
// Per-node NoC traffic generator: injects a programmed burst of multi-flit
// packets and checks every packet ejected at this node.
module noc_traffic_gen #(
    parameter int unsigned X_ID        = 0,
    parameter int unsigned Y_ID        = 0,
    parameter int unsigned X_SIZE      = 4,
    parameter int unsigned Y_SIZE      = 4,
    parameter int unsigned FLIT_W      = 32,
    parameter int unsigned MAX_PKT_LEN = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                               noc_clk_i,
    input  logic                               noc_rst_ni,
    input  logic                               start_i,
    input  logic [15:0]                        pkt_num_i,
    input  logic [$clog2(MAX_PKT_LEN+1)-1:0]   pkt_len_i,
    input  logic [1:0]                         dest_mode_i,
    input  logic [$clog2(X_SIZE)-1:0]          fixed_dst_x_i,
    input  logic [$clog2(Y_SIZE)-1:0]          fixed_dst_y_i,
    input  logic [7:0]                         gap_i,
    output logic                               tx_valid_o,
    input  logic                               tx_ready_i,
    output logic [FLIT_W-1:0]                  tx_flit_o,
    output logic                               tx_last_o,
    input  logic                               rx_valid_i,
    input  logic [FLIT_W-1:0]                  rx_flit_i,
    input  logic                               rx_last_i,
    output logic                               rx_ready_o,
    output logic                               busy_o,
    output logic                               done_o,
    output logic [15:0]                        tx_pkt_cnt_o,
    output logic [31:0]                        rx_flit_cnt_o,
    output logic [15:0]                        rx_err_cnt_o
);
    localparam int unsigned XW    = $clog2(X_SIZE);
    localparam int unsigned YW    = $clog2(Y_SIZE);
    localparam int unsigned LW    = $clog2(MAX_PKT_LEN + 1);
    localparam int unsigned SX_LO = XW + YW;
    localparam int unsigned SY_LO = 2 * XW + YW;

    localparam logic [XW-1:0] OWN_X = XW'(X_ID % X_SIZE);
    localparam logic [YW-1:0] OWN_Y = YW'(Y_ID % Y_SIZE);
    localparam logic [XW-1:0] TRN_X = XW'(Y_ID % X_SIZE);
    localparam logic [YW-1:0] TRN_Y = YW'(X_ID % Y_SIZE);
    localparam logic [XW-1:0] NBR_X = XW'((X_ID + 1) % X_SIZE);
    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_PKT_LEN);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HEAD = 2'd1;
    localparam logic [1:0] ST_BODY = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [15:0]   left_q, left_d, seq_q, seq_d, pkt_cnt_q, pkt_cnt_d, lfsr_q, lfsr_d;
    logic [LW-1:0] len_q, len_d, idx_q, idx_d;
    logic [7:0]    gap_q, gap_d, gcnt_q, gcnt_d;
    logic [1:0]    mode_q, mode_d, sel_mode;
    logic [XW-1:0] fx_q, fx_d, dx_q, dx_d, sel_fx, rnd_x, nxt_dx;
    logic [YW-1:0] fy_q, fy_d, dy_q, dy_d, sel_fy, rnd_y, nxt_dy;
    logic          done_q, done_d, eop, load_dst;

    // LFSR advances on every accepted head flit.
    assign lfsr_d = (state_q == ST_HEAD && tx_ready_i)
                  ? {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]}
                  : lfsr_q;

    // Destination for the next head; uses the post-advance LFSR so that a
    // head-only packet followed directly by another head sees a fresh value.
    always_comb begin
        sel_mode = (state_q == ST_IDLE) ? dest_mode_i   : mode_q;
        sel_fx   = (state_q == ST_IDLE) ? fixed_dst_x_i : fx_q;
        sel_fy   = (state_q == ST_IDLE) ? fixed_dst_y_i : fy_q;
        rnd_x    = lfsr_d[XW-1:0];
        rnd_y    = lfsr_d[XW+YW-1:XW];
        if (rnd_x == OWN_X && rnd_y == OWN_Y) rnd_x = rnd_x + XW'(1);
        case (sel_mode)
            2'd0:    begin nxt_dx = sel_fx; nxt_dy = sel_fy; end
            2'd1:    begin nxt_dx = rnd_x;  nxt_dy = rnd_y;  end
            2'd2:    begin nxt_dx = TRN_X;  nxt_dy = TRN_Y;  end
            default: begin nxt_dx = NBR_X;  nxt_dy = OWN_Y;  end
        endcase
    end

    // Transmit outputs decoded from the current state.
    always_comb begin
        tx_valid_o = (state_q == ST_HEAD) || (state_q == ST_BODY);
        tx_flit_o  = '0;
        tx_last_o  = 1'b0;
        if (state_q == ST_HEAD) begin
            tx_flit_o[XW-1:0]            = dx_q;
            tx_flit_o[XW+YW-1:XW]        = dy_q;
            tx_flit_o[SY_LO-1:SX_LO]     = OWN_X;
            tx_flit_o[SY_LO+YW-1:SY_LO]  = OWN_Y;
            tx_flit_o[FLIT_W-1 -: 16]    = seq_q;
            tx_last_o                    = (len_q == LW'(1));
        end else if (state_q == ST_BODY) begin
            tx_flit_o[FLIT_W-1 -: 16]    = seq_q;
            tx_flit_o[7:0]               = 8'(idx_q);
            tx_last_o                    = (idx_q == len_q - LW'(1));
        end
    end

    // Transmit FSM next-state logic.
    always_comb begin
        state_d   = state_q;
        left_d    = left_q;
        seq_d     = seq_q;
        pkt_cnt_d = pkt_cnt_q;
        len_d     = len_q;
        idx_d     = idx_q;
        gap_d     = gap_q;
        gcnt_d    = gcnt_q;
        mode_d    = mode_q;
        fx_d      = fx_q;
        fy_d      = fy_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        done_d    = 1'b0;
        eop       = 1'b0;
        load_dst  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    if (pkt_num_i == 16'd0) begin
                        done_d = 1'b1;
                    end else begin
                        left_d   = pkt_num_i;
                        len_d    = (pkt_len_i == '0) ? LW'(1)
                                 : (pkt_len_i > MAX_LEN) ? MAX_LEN : pkt_len_i;
                        gap_d    = gap_i;
                        mode_d   = dest_mode_i;
                        fx_d     = fixed_dst_x_i;
                        fy_d     = fixed_dst_y_i;
                        seq_d    = 16'd0;
                        state_d  = ST_HEAD;
                        load_dst = 1'b1;
                    end
                end
            end
            ST_HEAD: begin
                if (tx_ready_i) begin
                    if (tx_last_o) begin
                        eop = 1'b1;
                    end else begin
                        state_d = ST_BODY;
                        idx_d   = LW'(1);
                    end
                end
            end
            ST_BODY: begin
                if (tx_ready_i) begin
                    if (tx_last_o) eop = 1'b1;
                    else           idx_d = idx_q + LW'(1);
                end
            end
            default: begin
                if (gcnt_q <= 8'd1) begin
                    state_d  = ST_HEAD;
                    load_dst = 1'b1;
                end else begin
                    gcnt_d = gcnt_q - 8'd1;
                end
            end
        endcase
        if (eop) begin
            pkt_cnt_d = pkt_cnt_q + 16'd1;
            seq_d     = seq_q + 16'd1;
            left_d    = left_q - 16'd1;
            if (left_q == 16'd1) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else if (gap_q != 8'd0) begin
                state_d = ST_GAP;
                gcnt_d  = gap_q;
            end else begin
                state_d  = ST_HEAD;
                load_dst = 1'b1;
            end
        end
        if (load_dst) begin
            dx_d = nxt_dx;
            dy_d = nxt_dy;
        end
    end

    // Transmit state registers.
    always_ff @(posedge noc_clk_i or negedge noc_rst_ni) begin
        if (!noc_rst_ni) begin
            state_q   <= ST_IDLE;
            left_q    <= '0;
            seq_q     <= '0;
            pkt_cnt_q <= '0;
            lfsr_q    <= LFSR_SEED;
            len_q     <= LW'(1);
            idx_q     <= '0;
            gap_q     <= '0;
            gcnt_q    <= '0;
            mode_q    <= '0;
            fx_q      <= '0;
            fy_q      <= '0;
            dx_q      <= '0;
            dy_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            left_q    <= left_d;
            seq_q     <= seq_d;
            pkt_cnt_q <= pkt_cnt_d;
            lfsr_q    <= lfsr_d;
            len_q     <= len_d;
            idx_q     <= idx_d;
            gap_q     <= gap_d;
            gcnt_q    <= gcnt_d;
            mode_q    <= mode_d;
            fx_q      <= fx_d;
            fy_q      <= fy_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            done_q    <= done_d;
        end
    end

    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign tx_pkt_cnt_o = pkt_cnt_q;

    // Receive checker.
    logic        rx_exp_head_q, rx_err;
    logic [7:0]  rx_exp_idx_q;
    logic [15:0] rx_seq_q, rx_err_cnt_q;
    logic [31:0] rx_flit_cnt_q;
    logic        unused_rx_bits;

    assign unused_rx_bits = ^rx_flit_i;

    // One error per offending flit, whichever field is wrong.
    always_comb begin
        rx_err = 1'b0;
        if (rx_valid_i) begin
            if (rx_exp_head_q) begin
                rx_err = (rx_flit_i[XW-1:0] != OWN_X) || (rx_flit_i[XW+YW-1:XW] != OWN_Y);
            end else begin
                rx_err = (rx_flit_i[7:0] != rx_exp_idx_q)
                      || (rx_flit_i[FLIT_W-1 -: 16] != rx_seq_q);
            end
        end
    end

    // Receive expectation tracking and counters.
    always_ff @(posedge noc_clk_i or negedge noc_rst_ni) begin
        if (!noc_rst_ni) begin
            rx_exp_head_q <= 1'b1;
            rx_exp_idx_q  <= '0;
            rx_seq_q      <= '0;
            rx_flit_cnt_q <= '0;
            rx_err_cnt_q  <= '0;
        end else if (rx_valid_i) begin
            rx_flit_cnt_q <= rx_flit_cnt_q + 32'd1;
            if (rx_exp_head_q) begin
                rx_seq_q     <= rx_flit_i[FLIT_W-1 -: 16];
                rx_exp_idx_q <= 8'd1;
            end else begin
                rx_exp_idx_q <= rx_exp_idx_q + 8'd1;
            end
            rx_exp_head_q <= rx_last_i;
            if (rx_err && rx_err_cnt_q != 16'hFFFF) rx_err_cnt_q <= rx_err_cnt_q + 16'd1;
        end
    end

    assign rx_ready_o    = 1'b1;
    assign rx_flit_cnt_o = rx_flit_cnt_q;
    assign rx_err_cnt_o  = rx_err_cnt_q;

endmodule

// File: tb/tb_noc_traffic_gen.sv
// Directed bench for noc_traffic_gen: node (1,1) for most scenarios and
// node (0,0) for the random-destination burst.
module tb_noc_traffic_gen;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_a = 1'b0, start_b = 1'b0;
    logic [15:0] pkt_num = '0;
    logic [3:0]  pkt_len = '0;
    logic [1:0]  dest_mode = '0, fdx = '0, fdy = '0;
    logic [7:0]  gap = '0;
    logic        tx_ready = 1'b1;
    logic        lb_en = 1'b0;
    logic [31:0] corrupt = '0;

    logic        a_valid, a_last, a_rx_ready, a_busy, a_done;
    logic [31:0] a_flit, a_rx_cnt, a_rx_flit;
    logic [15:0] a_pkt_cnt, a_err_cnt;
    logic        a_rx_valid, a_rx_last;
    logic        b_valid, b_last, b_rx_ready, b_busy, b_done;
    logic [31:0] b_flit, b_rx_cnt;
    logic [15:0] b_pkt_cnt, b_err_cnt;
    logic        zero1 = 1'b0;
    logic [31:0] zero32 = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign a_rx_valid = lb_en & a_valid & tx_ready;
    assign a_rx_flit  = a_flit ^ corrupt;
    assign a_rx_last  = a_last;

    noc_traffic_gen #(.X_ID(1), .Y_ID(1)) dut_a (
        .noc_clk_i(clk), .noc_rst_ni(rst_n), .start_i(start_a), .pkt_num_i(pkt_num),
        .pkt_len_i(pkt_len), .dest_mode_i(dest_mode), .fixed_dst_x_i(fdx),
        .fixed_dst_y_i(fdy), .gap_i(gap), .tx_valid_o(a_valid), .tx_ready_i(tx_ready),
        .tx_flit_o(a_flit), .tx_last_o(a_last), .rx_valid_i(a_rx_valid),
        .rx_flit_i(a_rx_flit), .rx_last_i(a_rx_last), .rx_ready_o(a_rx_ready),
        .busy_o(a_busy), .done_o(a_done), .tx_pkt_cnt_o(a_pkt_cnt),
        .rx_flit_cnt_o(a_rx_cnt), .rx_err_cnt_o(a_err_cnt)
    );

    noc_traffic_gen #(.X_ID(0), .Y_ID(0)) dut_b (
        .noc_clk_i(clk), .noc_rst_ni(rst_n), .start_i(start_b), .pkt_num_i(pkt_num),
        .pkt_len_i(pkt_len), .dest_mode_i(dest_mode), .fixed_dst_x_i(fdx),
        .fixed_dst_y_i(fdy), .gap_i(gap), .tx_valid_o(b_valid), .tx_ready_i(tx_ready),
        .tx_flit_o(b_flit), .tx_last_o(b_last), .rx_valid_i(zero1),
        .rx_flit_i(zero32), .rx_last_i(zero1), .rx_ready_o(b_rx_ready),
        .busy_o(b_busy), .done_o(b_done), .tx_pkt_cnt_o(b_pkt_cnt),
        .rx_flit_cnt_o(b_rx_cnt), .rx_err_cnt_o(b_err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        start_a = 1'b0; start_b = 1'b0; lb_en = 1'b0; corrupt = '0; tx_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Burst of 3 x 4 flits to (2,1) from node (1,1); flit k of the burst.
    function automatic logic [31:0] basic_flit(int k);
        logic [15:0] s;
        logic [7:0]  i;
        s = 16'(k / 4);
        i = 8'(k % 4);
        return (i == 8'd0) ? {s, 16'h0056} : {s, 8'h00, i};
    endfunction

    task automatic cfg_basic();
        pkt_num = 16'd3; pkt_len = 4'd4; dest_mode = 2'd0; fdx = 2'd2; fdy = 2'd1; gap = 8'd0;
    endtask

    task automatic test_reset();
        start_a = 1'b0; start_b = 1'b0;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({a_valid, a_last, a_busy, a_done} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000", {a_valid, a_last, a_busy, a_done});
        end
        checks++;
        if (a_flit !== 32'h0) begin
            errors++; $display("FAIL reset_flit: got %h expected 0", a_flit);
        end
        checks++;
        if ({a_pkt_cnt, a_rx_cnt, a_err_cnt} !== 64'h0) begin
            errors++;
            $display("FAIL reset_cnt: got %h %h %h expected 0", a_pkt_cnt, a_rx_cnt, a_err_cnt);
        end
        checks++;
        if (a_rx_ready !== 1'b1) begin
            errors++; $display("FAIL reset_rx_ready: got %b expected 1", a_rx_ready);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_zero_pkts();
        do_reset();
        cfg_basic();
        pkt_num = 16'd0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        checks++;
        if ({a_done, a_busy, a_valid} !== 3'b100) begin
            errors++; $display("FAIL zero_done: got %b expected 100", {a_done, a_busy, a_valid});
        end
        tick();
        checks++;
        if (a_done !== 1'b0) begin
            errors++; $display("FAIL zero_done_pulse: got %b expected 0", a_done);
        end
    endtask

    task automatic test_basic();
        do_reset();
        cfg_basic();
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            // A start while busy must be ignored, including its new destination.
            if (c == 5) begin start_a = 1'b1; fdx = 2'd0; end
            if (c == 6) begin start_a = 1'b0; fdx = 2'd2; end
            checks++;
            if ({a_valid, a_last, a_busy, a_flit} !==
                {1'b1, ((c - 1) % 4 == 3), 1'b1, basic_flit(c - 1)}) begin
                errors++;
                $display("FAIL basic_c%0d: got v=%b l=%b b=%b f=%h expected v=1 l=%b b=1 f=%h",
                         c, a_valid, a_last, a_busy, a_flit, ((c - 1) % 4 == 3),
                         basic_flit(c - 1));
            end
            tick();
        end
        start_a = 1'b0;
        checks++;
        if ({a_done, a_busy, a_valid} !== 3'b100) begin
            errors++; $display("FAIL basic_done: got %b expected 100", {a_done, a_busy, a_valid});
        end
        checks++;
        if (a_pkt_cnt !== 16'd3) begin
            errors++; $display("FAIL basic_pkt_cnt: got %0d expected 3", a_pkt_cnt);
        end
        tick();
        checks++;
        if (a_done !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse: got %b expected 0", a_done);
        end
    endtask

    task automatic test_stall();
        int k;
        do_reset();
        cfg_basic();
        k = 0;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            tx_ready = (c % 2 == 1);
            checks++;
            if ({a_valid, a_last, a_flit} !== {1'b1, (k % 4 == 3), basic_flit(k)}) begin
                errors++;
                $display("FAIL stall_c%0d: got v=%b l=%b f=%h expected v=1 l=%b f=%h",
                         c, a_valid, a_last, a_flit, (k % 4 == 3), basic_flit(k));
            end
            if (tx_ready) k++;
            tick();
        end
        tx_ready = 1'b1;
        checks++;
        if ({a_done, a_busy} !== 2'b10 || a_pkt_cnt !== 16'd3) begin
            errors++;
            $display("FAIL stall_done: got done=%b busy=%b cnt=%0d expected 1 0 3",
                     a_done, a_busy, a_pkt_cnt);
        end
    endtask

    task automatic test_len1_gap();
        do_reset();
        cfg_basic();
        pkt_num = 16'd4; pkt_len = 4'd0; gap = 8'd2;
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checks++;
            if ((c - 1) % 3 == 0) begin
                if ({a_valid, a_last, a_flit} !== {2'b11, 16'((c - 1) / 3), 16'h0056}) begin
                    errors++;
                    $display("FAIL gap_head_c%0d: got v=%b l=%b f=%h expected v=1 l=1 f=%h",
                             c, a_valid, a_last, a_flit, {16'((c - 1) / 3), 16'h0056});
                end
            end else if ({a_valid, a_busy} !== 2'b01) begin
                errors++;
                $display("FAIL gap_idle_c%0d: got v=%b b=%b expected v=0 b=1", c, a_valid, a_busy);
            end
            tick();
        end
        checks++;
        if ({a_done, a_busy} !== 2'b10 || a_pkt_cnt !== 16'd4) begin
            errors++;
            $display("FAIL gap_done: got done=%b busy=%b cnt=%0d expected 1 0 4",
                     a_done, a_busy, a_pkt_cnt);
        end
    endtask

    task automatic test_random();
        logic [15:0] l;
        logic [1:0]  dx, dy;
        do_reset();
        pkt_num = 16'd32; pkt_len = 4'd1; dest_mode = 2'd1; gap = 8'd0;
        l = 16'hACE1;
        start_b = 1'b1; tick(); start_b = 1'b0;
        for (int k = 0; k < 32; k++) begin
            dx = l[1:0];
            dy = l[3:2];
            if (dx == 2'd0 && dy == 2'd0) dx = 2'd1;
            checks++;
            if ({b_valid, b_last, b_flit} !== {2'b11, 16'(k), 12'h000, dy, dx}) begin
                errors++;
                $display("FAIL random_pkt%0d: got v=%b l=%b f=%h expected v=1 l=1 f=%h",
                         k, b_valid, b_last, b_flit, {16'(k), 12'h000, dy, dx});
            end
            checks++;
            if (b_flit[3:0] === 4'h0) begin
                errors++; $display("FAIL random_self%0d: got dst %h expected not 0", k, b_flit[3:0]);
            end
            l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            tick();
        end
        checks++;
        if ({b_done, b_busy} !== 2'b10) begin
            errors++; $display("FAIL random_done: got %b expected 10", {b_done, b_busy});
        end
    endtask

    task automatic wait_done_a(input string name);
        int n;
        n = 0;
        while (a_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (a_done !== 1'b1) begin
            errors++; $display("FAIL %s_timeout: got done=%b expected 1", name, a_done);
        end
    endtask

    task automatic test_loopback();
        do_reset();
        pkt_num = 16'd3; pkt_len = 4'd4; dest_mode = 2'd2; gap = 8'd1;
        lb_en = 1'b1;
        start_a = 1'b1; tick(); start_a = 1'b0;
        checks++;
        if (a_flit !== 32'h0000_0055) begin
            errors++; $display("FAIL lb_head: got %h expected 00000055", a_flit);
        end
        wait_done_a("lb_clean");
        checks++;
        if (a_rx_cnt !== 32'd12 || a_err_cnt !== 16'd0) begin
            errors++;
            $display("FAIL lb_clean_cnt: got rx=%0d err=%0d expected 12 0", a_rx_cnt, a_err_cnt);
        end
        tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        tick();
        tick();
        corrupt = 32'h1;   // body flit 2 is on the bus this cycle
        tick();
        corrupt = 32'h0;
        wait_done_a("lb_bad");
        checks++;
        if (a_rx_cnt !== 32'd24 || a_err_cnt !== 16'd1) begin
            errors++;
            $display("FAIL lb_bad_cnt: got rx=%0d err=%0d expected 24 1", a_rx_cnt, a_err_cnt);
        end
        lb_en = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        cfg_basic();
        start_a = 1'b1; tick(); start_a = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        checks++;
        if ({a_valid, a_pkt_cnt, a_flit} !== {1'b1, 16'd1, 16'd1, 16'd1}) begin
            errors++;
            $display("FAIL mid_pre: got v=%b cnt=%0d f=%h expected 1 1 00010001",
                     a_valid, a_pkt_cnt, a_flit);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({a_valid, a_busy, a_last, a_pkt_cnt} !== 19'h0) begin
            errors++;
            $display("FAIL mid_async: got v=%b b=%b l=%b cnt=%0d expected 0 0 0 0",
                     a_valid, a_busy, a_last, a_pkt_cnt);
        end
        tick();
        rst_n = 1'b1;
        tick();
        start_a = 1'b1; tick(); start_a = 1'b0;
        checks++;
        if ({a_valid, a_flit} !== {1'b1, 32'h0000_0056}) begin
            errors++;
            $display("FAIL mid_restart: got v=%b f=%h expected v=1 f=00000056", a_valid, a_flit);
        end
        wait_done_a("mid_restart");
    endtask

    initial begin
        test_reset();
        test_zero_pkts();
        test_basic();
        test_stall();
        test_len1_gap();
        test_random();
        test_loopback();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end
endmodule
